// File: rtl/tinyodin_obi_demux.sv
// OBI subordinate-side demux: one bus port fanned out to NUM_TARGETS targets by an
// address field, with an in-order FIFO that steers each response back from the granted target.
module tinyodin_obi_demux #(
  parameter int NUM_TARGETS     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SEL_LSB         = 20,
  parameter int SEL_WIDTH       = 2,
  parameter int ADDR_SHIFT      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              mgr_req_i,
  input  logic                              mgr_we_i,
  input  logic [DATA_WIDTH/8-1:0]           mgr_be_i,
  input  logic [ADDR_WIDTH-1:0]             mgr_addr_i,
  input  logic [DATA_WIDTH-1:0]             mgr_wdata_i,
  output logic                              mgr_gnt_o,
  output logic                              mgr_rvalid_o,
  output logic [DATA_WIDTH-1:0]             mgr_rdata_o,
  output logic                              mgr_err_o,
  output logic [NUM_TARGETS-1:0]            tgt_req_o,
  output logic                              tgt_we_o,
  output logic [DATA_WIDTH/8-1:0]           tgt_be_o,
  output logic [ADDR_WIDTH-1:0]             tgt_addr_o,
  output logic [DATA_WIDTH-1:0]             tgt_wdata_o,
  input  logic [NUM_TARGETS-1:0]            tgt_gnt_i,
  input  logic [NUM_TARGETS-1:0]            tgt_rvalid_i,
  input  logic [NUM_TARGETS*DATA_WIDTH-1:0] tgt_rdata_i,
  output logic                              proto_err_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SEL_WIDTH:0] NT = (SEL_WIDTH+1)'(NUM_TARGETS);

  typedef struct packed {
    logic                 err;
    logic [SEL_WIDTH-1:0] sel;
  } ent_t;

  ent_t                 fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 proto_q, proto_d;

  logic [SEL_WIDTH-1:0] sel;
  logic                 is_err, full, empty, push, pop;
  logic [NUM_TARGETS-1:0] unexp;
  ent_t                 head;

  assign sel    = mgr_addr_i[SEL_LSB +: SEL_WIDTH];
  assign is_err = {1'b0, sel} >= NT;
  assign full   = cnt_q == CW'(MAX_OUTSTANDING);
  assign empty  = cnt_q == '0;
  assign head   = fifo_q[rptr_q];

  assign tgt_we_o    = mgr_we_i;
  assign tgt_be_o    = mgr_be_i;
  assign tgt_addr_o  = mgr_addr_i >> ADDR_SHIFT;
  assign tgt_wdata_o = mgr_wdata_i;
  assign proto_err_o = proto_q;

  // Request path: full blocks everything, including local error grants.
  always_comb begin
    tgt_req_o = '0;
    mgr_gnt_o = 1'b0;
    if (rst_ni && !full) begin
      if (is_err) begin
        mgr_gnt_o = mgr_req_i;
      end else begin
        for (int k = 0; k < NUM_TARGETS; k++) begin
          if (sel == SEL_WIDTH'(k)) begin
            tgt_req_o[k] = mgr_req_i;
            mgr_gnt_o    = tgt_gnt_i[k];
          end
        end
      end
    end
  end

  // Response path follows the FIFO head only; any other rvalid is a protocol error.
  always_comb begin
    mgr_rvalid_o = 1'b0;
    mgr_rdata_o  = '0;
    mgr_err_o    = 1'b0;
    unexp        = tgt_rvalid_i;
    if (rst_ni && !empty) begin
      if (head.err) begin
        mgr_rvalid_o = 1'b1;
        mgr_err_o    = 1'b1;
      end else begin
        for (int k = 0; k < NUM_TARGETS; k++) begin
          if (head.sel == SEL_WIDTH'(k)) begin
            mgr_rvalid_o = tgt_rvalid_i[k];
            mgr_rdata_o  = tgt_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            unexp[k]     = 1'b0;
          end
        end
      end
    end
  end

  assign push    = mgr_req_i & mgr_gnt_o;
  assign pop     = mgr_rvalid_o;
  assign proto_d = proto_q | (|unexp);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      proto_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      proto_q <= proto_d;
      if (push) begin
        fifo_q[wptr_q] <= '{err: is_err, sel: sel};
        wptr_q <= (wptr_q == PW'(MAX_OUTSTANDING-1)) ? '0 : wptr_q + PW'(1);
      end
      if (pop) rptr_q <= (rptr_q == PW'(MAX_OUTSTANDING-1)) ? '0 : rptr_q + PW'(1);
    end
  end

endmodule

// File: tb/tb_tinyodin_obi_demux.sv
// Directed bench for tinyodin_obi_demux: a 4-target instance for routing/ordering/full/reset,
// and a 3-target instance sharing the same inputs for the unmapped-select error path.
module tb_tinyodin_obi_demux;
  logic         clk, rst_n;
  logic         req, we;
  logic [3:0]   be;
  logic [31:0]  addr, wdata;
  logic [3:0]   tgt_gnt, tgt_rvalid;
  logic [127:0] tgt_rdata;

  logic        a_gnt, a_rvalid, a_err, a_twe, a_proto;
  logic [31:0] a_rdata, a_taddr, a_twdata;
  logic [3:0]  a_treq, a_tbe;
  logic        b_gnt, b_rvalid, b_err, b_twe, b_proto;
  logic [31:0] b_rdata, b_taddr, b_twdata;
  logic [2:0]  b_treq;
  logic [3:0]  b_tbe;

  int n_chk = 0;
  int n_err = 0;

  tinyodin_obi_demux #(.NUM_TARGETS(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .mgr_req_i(req), .mgr_we_i(we), .mgr_be_i(be),
    .mgr_addr_i(addr), .mgr_wdata_i(wdata), .mgr_gnt_o(a_gnt), .mgr_rvalid_o(a_rvalid),
    .mgr_rdata_o(a_rdata), .mgr_err_o(a_err), .tgt_req_o(a_treq), .tgt_we_o(a_twe),
    .tgt_be_o(a_tbe), .tgt_addr_o(a_taddr), .tgt_wdata_o(a_twdata), .tgt_gnt_i(tgt_gnt),
    .tgt_rvalid_i(tgt_rvalid), .tgt_rdata_i(tgt_rdata), .proto_err_o(a_proto));

  tinyodin_obi_demux #(.NUM_TARGETS(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .mgr_req_i(req), .mgr_we_i(we), .mgr_be_i(be),
    .mgr_addr_i(addr), .mgr_wdata_i(wdata), .mgr_gnt_o(b_gnt), .mgr_rvalid_o(b_rvalid),
    .mgr_rdata_o(b_rdata), .mgr_err_o(b_err), .tgt_req_o(b_treq), .tgt_we_o(b_twe),
    .tgt_be_o(b_tbe), .tgt_addr_o(b_taddr), .tgt_wdata_o(b_twdata), .tgt_gnt_i(tgt_gnt[2:0]),
    .tgt_rvalid_i(tgt_rvalid[2:0]), .tgt_rdata_i(tgt_rdata[95:0]), .proto_err_o(b_proto));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks sample 1ns later.
  task automatic step;
    @(negedge clk);
  endtask

  task automatic idle;
    req = 1'b0; we = 1'b0; be = 4'hF; wdata = '0;
    tgt_gnt = '0; tgt_rvalid = '0; tgt_rdata = '0;
  endtask

  task automatic do_reset;
    step; rst_n = 1'b0; idle;
    step;
    step; rst_n = 1'b1;
  endtask

  initial begin
    // Reset: outputs forced low even with active inputs.
    rst_n = 1'b0; idle; addr = 32'h0;
    req = 1'b1; tgt_gnt = 4'hF; tgt_rvalid = 4'hF; tgt_rdata = '1;
    step; #1;
    chk("rst_treq", a_treq, 0); chk("rst_gnt", a_gnt, 0);
    chk("rst_rvalid", a_rvalid, 0); chk("rst_rdata", a_rdata, 0); chk("rst_err", a_err, 0);
    chk("rst_b_gnt", b_gnt, 0);
    step; #1; chk("rst_proto", a_proto, 0);
    rst_n = 1'b1; idle;
    step; #1; chk("rst_proto_after", a_proto, 0); chk("rst_empty", a_rvalid, 0);

    // 1: simple read to tgt1.
    step; req = 1'b1; addr = 32'h0010_0008; tgt_gnt = 4'b0010; #1;
    chk("t1_treq", a_treq, 4'b0010); chk("t1_taddr", a_taddr, 32'h0004_0002);
    chk("t1_gnt", a_gnt, 1);
    step; idle; tgt_rvalid = 4'b0010; tgt_rdata[63:32] = 32'hCAFE; #1;
    chk("t1_rvalid", a_rvalid, 1); chk("t1_rdata", a_rdata, 32'hCAFE); chk("t1_err", a_err, 0);
    step; idle; #1;
    chk("t1_done", a_rvalid, 0); chk("t1_proto", a_proto, 0);

    // 2: tgt2 answers before tgt0.
    step; req = 1'b1; addr = 32'h0000_0000; tgt_gnt = 4'b0001; #1; chk("t2_gnt0", a_gnt, 1);
    step; addr = 32'h0020_0000; tgt_gnt = 4'b0100; #1;
    chk("t2_treq2", a_treq, 4'b0100); chk("t2_gnt2", a_gnt, 1);
    step; idle; tgt_rvalid = 4'b0100; tgt_rdata[95:64] = 32'h2222; #1;
    chk("t2_drop", a_rvalid, 0);
    step; idle; tgt_rvalid = 4'b0001; tgt_rdata[31:0] = 32'h1111; #1;
    chk("t2_proto", a_proto, 1); chk("t2_rv0", a_rvalid, 1); chk("t2_rd0", a_rdata, 32'h1111);
    step; idle; tgt_rvalid = 4'b0100; tgt_rdata[95:64] = 32'h2222; #1;
    chk("t2_rv2", a_rvalid, 1); chk("t2_rd2", a_rdata, 32'h2222);
    step; idle; #1; chk("t2_empty", a_rvalid, 0);
    do_reset;

    // 3: order preserved while address wanders.
    step; req = 1'b1; addr = 32'h0030_0000; tgt_gnt = 4'b1000; #1; chk("t3_gnt3", a_gnt, 1);
    step; addr = 32'h0000_0000; tgt_gnt = 4'b0001; #1; chk("t3_gnt0", a_gnt, 1);
    step; idle; addr = 32'h0010_0000; tgt_rvalid = 4'b1000;
    tgt_rdata[127:96] = 32'h3333; tgt_rdata[31:0] = 32'h0BAD; #1;
    chk("t3_rv3", a_rvalid, 1); chk("t3_rd3", a_rdata, 32'h3333);
    step; idle; addr = 32'h0020_0000; tgt_rvalid = 4'b0001;
    tgt_rdata[31:0] = 32'h0000_1000; tgt_rdata[127:96] = 32'hDEAD; #1;
    chk("t3_rv0", a_rvalid, 1); chk("t3_rd0", a_rdata, 32'h0000_1000);
    step; idle; #1; chk("t3_proto", a_proto, 0);
    do_reset;

    // 4: unmapped select on the 3-target instance.
    step; req = 1'b1; addr = 32'h0030_0000; #1;
    chk("t4_b_gnt", b_gnt, 1); chk("t4_b_treq", b_treq, 0);
    chk("t4_a_treq", a_treq, 4'b1000); chk("t4_a_gnt", a_gnt, 0);
    step; idle; #1;
    chk("t4_b_rvalid", b_rvalid, 1); chk("t4_b_err", b_err, 1); chk("t4_b_rdata", b_rdata, 0);
    step; #1; chk("t4_b_done", b_rvalid, 0); chk("t4_b_proto", b_proto, 0);
    do_reset;

    // 5: outstanding limit of two.
    step; req = 1'b1; addr = 32'h0010_0000; tgt_gnt = 4'b0010; #1; chk("t5_g1", a_gnt, 1);
    step; #1; chk("t5_g2", a_gnt, 1);
    step; #1; chk("t5_full_gnt", a_gnt, 0); chk("t5_full_treq", a_treq, 0);
    step; tgt_rvalid = 4'b0010; tgt_rdata[63:32] = 32'h5; #1;
    chk("t5_pop_gnt", a_gnt, 0); chk("t5_pop_treq", a_treq, 0); chk("t5_pop_rv", a_rvalid, 1);
    step; tgt_rvalid = 4'b0000; #1;
    chk("t5_g3_treq", a_treq, 4'b0010); chk("t5_g3", a_gnt, 1);
    step; idle; tgt_rvalid = 4'b0010; #1; chk("t5_rv2", a_rvalid, 1);
    step; #1; chk("t5_rv3", a_rvalid, 1);
    step; idle; #1; chk("t5_empty", a_rvalid, 0); chk("t5_proto", a_proto, 0);

    // 6: reset with two outstanding, then a late rvalid.
    do_reset;
    step; req = 1'b1; addr = 32'h0; tgt_gnt = 4'b0001; #1; chk("t6_g1", a_gnt, 1);
    step; #1; chk("t6_g2", a_gnt, 1);
    step; rst_n = 1'b0; tgt_rvalid = 4'b0001; tgt_rdata[31:0] = 32'h6666; #1;
    chk("t6_rst_treq", a_treq, 0); chk("t6_rst_gnt", a_gnt, 0);
    chk("t6_rst_rv", a_rvalid, 0); chk("t6_rst_rd", a_rdata, 0); chk("t6_rst_err", a_err, 0);
    step; #1; chk("t6_rst_proto", a_proto, 0);
    step; rst_n = 1'b1; idle; tgt_rvalid = 4'b0001; tgt_rdata[31:0] = 32'h6666; #1;
    chk("t6_late_rv", a_rvalid, 0); chk("t6_late_rd", a_rdata, 0);
    step; idle; #1; chk("t6_proto", a_proto, 1);
    step; #1; chk("t6_sticky", a_proto, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
